// File: rtl/conv_result_reader.sv
// rtl/conv_result_reader.sv - sequential result read-back with latency-absorbing output FIFO
// Optional checksum output enabled by defining RESULT_READER_CHECKSUM_EN.
module conv_result_reader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef RESULT_READER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic [MEM_LAT-1:0] pipe;
    logic [7:0]        inflight;
    logic [7:0]        occupancy;
    logic              credit;
    logic              issue;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + 8'(pipe[i]);
        end
    end

    // Every read in flight already owns a FIFO slot, so a push can never find the FIFO full.
    assign occupancy   = 8'(fifo_cnt) + inflight;
    assign credit      = occupancy < 8'(FIFO_DEPTH);
    assign issue       = (state == S_ISSUE) && credit;
    assign push        = pipe[MEM_LAT-1];
    assign pop         = out_valid && out_ready;

    assign mem_read_en = issue;
    assign mem_addr    = addr_q;
    assign out_valid   = (fifo_cnt != '0);
    assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;
    assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
    assign done        = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            pipe     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        rem_q  <= word_count;
                        state  <= (word_count == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (credit) begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == ADDR_W'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // An empty FIFO with nothing in flight means the last word has been accepted.
                    if ((inflight == '0) && (fifo_cnt == '0)) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RESULT_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if ((state == S_IDLE) && start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + 16'(out_data);
        end
    end
`endif

    assert property (@(posedge clk) disable iff (!rst) !(push && (fifo_cnt == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_conv_result_reader.sv
// tb/tb_conv_result_reader.sv - randomized self-checking bench for conv_result_reader
module tb_conv_result_reader;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic [15:0] mem_addr;
    logic        mem_read_en;
    logic [7:0]  mem_rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef RESULT_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    conv_result_reader #(.DATA_W(8), .ADDR_W(16), .MEM_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
`ifdef RESULT_READER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    logic [7:0] mem_model [0:65535];
    always @(posedge clk) begin
        if (mem_read_en) mem_rdata <= mem_model[mem_addr];
    end

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  got_q[$];
    logic [15:0] addr_obs[$];
    logic [7:0]  exp_q[$];
    int done_cnt, done_cycle, first_issue, first_word, last_word;
    int unstable, credit_bad, stall_cycles, busy_bad, valid_seen, timeout;
    logic        busy_at_done;
    logic [15:0] chk_at_done;

    function automatic logic ready_for(int mode, int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return 1'($urandom % 2);
    endfunction

    task automatic build_expected(input logic [15:0] b, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem_model[b + 16'(i)]);
    endtask

    task automatic run_job(input logic [15:0] b, input logic [15:0] n, input int mode,
                           input int glitch_cyc, input int max_cyc);
        int issued = 0;
        int popped = 0;
        int outstanding;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        got_q.delete(); addr_obs.delete();
        done_cnt = 0; done_cycle = -1; first_issue = -1; first_word = -1; last_word = -1;
        unstable = 0; credit_bad = 0; stall_cycles = 0; busy_bad = 0; valid_seen = 0;
        timeout = 0; busy_at_done = 1'b1; chk_at_done = '0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(posedge clk); #1;
            start      = (cyc == 0) || (cyc == glitch_cyc);
            base_addr  = (cyc == 0) ? b : ~b;
            word_count = (cyc == 0) ? n : n + 16'd5;
            out_ready  = ready_for(mode, cyc);
            @(negedge clk);
            outstanding = issued - popped;
            if (outstanding >= DEPTH && issued < int'(n)) stall_cycles++;
            if (mem_read_en) begin
                addr_obs.push_back(mem_addr);
                issued++;
                if (first_issue < 0) first_issue = cyc;
                if (outstanding >= DEPTH) credit_bad++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                popped++;
                if (first_word < 0) first_word = cyc;
                last_word = cyc;
            end
            if (out_valid) valid_seen = 1;
            if (prev_stall && out_data !== prev_data) unstable++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (cyc >= 1 && done_cycle < 0 && n != 0 && !done && busy !== 1'b1) busy_bad++;
            if (done_cycle >= 0 && cyc > done_cycle && busy !== 1'b0) busy_bad++;
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) begin
                    done_cycle   = cyc;
                    busy_at_done = busy;
`ifdef RESULT_READER_CHECKSUM_EN
                    chk_at_done  = checksum;
`endif
                end
            end
            if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
        end
        if (done_cycle < 0) timeout = 1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; word_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({mem_addr, mem_read_en, out_valid, out_data, busy, done} !== 29'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got addr=%h ren=%b vld=%b data=%h busy=%b done=%b, want all 0",
                     mem_addr, mem_read_en, out_valid, out_data, busy, done);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_read();
        mem_model[16'h40] = 8'h11; mem_model[16'h41] = 8'h22;
        mem_model[16'h42] = 8'h33; mem_model[16'h43] = 8'h44;
        run_job(16'h0040, 16'd4, 0, -1, 40);
        build_expected(16'h0040, 4);
        tests_run++;
        if (timeout != 0 || got_q.size() != 4) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d words timeout=%0d, want 4 words", got_q.size(), timeout);
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (last_word - first_word !== 3) begin
            tests_failed++;
            $display("FAIL basic_back_to_back: span %0d cycles, want 3", last_word - first_word);
        end
        tests_run++;
        if (first_word - first_issue !== LAT + 1) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d want %0d", first_word - first_issue, LAT + 1);
        end
        tests_run++;
        if (done_cnt !== 1 || busy_at_done !== 1'b0 || busy_bad !== 0) begin
            tests_failed++;
            $display("FAIL basic_done_busy: done_cnt=%0d busy_at_done=%b busy_bad=%0d, want 1/0/0",
                     done_cnt, busy_at_done, busy_bad);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] b = 16'($urandom);
        run_job(b, 16'd8, 1, -1, 200);
        build_expected(b, 8);
        tests_run++;
        if (timeout != 0 || got_q.size() != 8) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d words timeout=%0d, want 8", got_q.size(), timeout);
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (unstable !== 0 || credit_bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_stability_credit: unstable=%0d credit_bad=%0d, want 0/0", unstable, credit_bad);
        end
        tests_run++;
        if (stall_cycles == 0) begin
            tests_failed++;
            $display("FAIL bp_stall: got %0d full-credit cycles, want >0", stall_cycles);
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL bp_done: got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_zero_count();
        run_job(16'($urandom), 16'd0, 0, -1, 20);
        tests_run++;
        if (addr_obs.size() != 0 || valid_seen != 0 || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_activity: reads=%0d valid_seen=%0d words=%0d, want 0/0/0",
                     addr_obs.size(), valid_seen, got_q.size());
        end
        tests_run++;
        if (done_cnt !== 1 || done_cycle < 1 || done_cycle > 2) begin
            tests_failed++;
            $display("FAIL zero_done: pulses=%0d at cycle %0d, want 1 within 2 cycles", done_cnt, done_cycle);
        end
    endtask

    task automatic test_addr_wrap();
        run_job(16'hFFFE, 16'd3, 0, -1, 40);
        build_expected(16'hFFFE, 3);
        tests_run++;
        if (addr_obs.size() != 3) begin
            tests_failed++;
            $display("FAIL wrap_reads: got %0d reads want 3", addr_obs.size());
        end
        for (int i = 0; i < 3 && i < addr_obs.size(); i++) begin
            tests_run++;
            if (addr_obs[i] !== 16'hFFFE + 16'(i)) begin
                tests_failed++;
                $display("FAIL wrap_addr%0d: got %h want %h", i, addr_obs[i], 16'hFFFE + 16'(i));
            end
        end
        tests_run++;
        if (got_q != exp_q) begin
            tests_failed++;
            $display("FAIL wrap_data: got %p want %p", got_q, exp_q);
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] b = 16'($urandom);
        run_job(b, 16'd6, 1, 3, 200);
        build_expected(b, 6);
        tests_run++;
        if (got_q != exp_q || addr_obs.size() != 6 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL busy_start: words=%0d reads=%0d done=%0d, want 6/6/1 with unchanged data",
                     got_q.size(), addr_obs.size(), done_cnt);
        end
    endtask

    task automatic test_random_jobs();
        for (int k = 0; k < 6; k++) begin
            logic [15:0] b = 16'($urandom);
            logic [15:0] n = 16'($urandom_range(1, 12));
            logic [15:0] sum = '0;
            run_job(b, n, 2, -1, 400);
            build_expected(b, int'(n));
            foreach (exp_q[i]) sum = sum + 16'(exp_q[i]);
            tests_run++;
            if (timeout != 0 || got_q != exp_q || unstable != 0 || credit_bad != 0 || done_cnt != 1) begin
                tests_failed++;
                $display("FAIL rand_job%0d: words=%0d want %0d unstable=%0d credit_bad=%0d done=%0d timeout=%0d",
                         k, got_q.size(), n, unstable, credit_bad, done_cnt, timeout);
            end
`ifdef RESULT_READER_CHECKSUM_EN
            tests_run++;
            if (chk_at_done !== sum) begin
                tests_failed++;
                $display("FAIL rand_checksum%0d: got %h want %h", k, chk_at_done, sum);
            end
`endif
        end
    endtask

    task automatic test_reset_midrun();
        int seen = 0;
        int done_seen = 0;
        logic hit = 1'b0;
        logic [15:0] b2 = 16'($urandom);
        for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 0); base_addr = 16'($urandom); word_count = 16'd8; out_ready = 1'b1;
            @(negedge clk);
            if (seen == 2 && out_valid) begin
                rst = 1'b0;
                #1;
                hit = 1'b1;
                tests_run++;
                if ({mem_addr, mem_read_en, out_valid, out_data, busy, done} !== 29'd0) begin
                    tests_failed++;
                    $display("FAIL midrun_reset_outputs: addr=%h ren=%b vld=%b data=%h busy=%b done=%b, want 0",
                             mem_addr, mem_read_en, out_valid, out_data, busy, done);
                end
            end else if (out_valid && out_ready) begin
                seen++;
            end
        end
        start = 1'b0;
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL midrun_reach_third: saw %0d words, want reset during third", seen);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        tests_run++;
        if (done_seen !== 0) begin
            tests_failed++;
            $display("FAIL midrun_no_done: got %0d pulses want 0", done_seen);
        end
        run_job(b2, 16'd2, 0, -1, 40);
        build_expected(b2, 2);
        tests_run++;
        if (got_q != exp_q || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL midrun_restart: words=%0d done=%0d, want 2 correct words and 1 done",
                     got_q.size(), done_cnt);
        end
    endtask

`ifdef RESULT_READER_CHECKSUM_EN
    task automatic test_checksum();
        mem_model[16'h1000] = 8'hFF; mem_model[16'h1001] = 8'hFF; mem_model[16'h1002] = 8'h02;
        run_job(16'h1000, 16'd3, 0, -1, 40);
        tests_run++;
        if (chk_at_done !== 16'h0200) begin
            tests_failed++;
            $display("FAIL checksum_fixed: got %h want 0200", chk_at_done);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem_model[i] = 8'($urandom);
        test_reset();
        test_basic_read();
        test_backpressure();
        test_zero_count();
        test_addr_wrap();
        test_start_while_busy();
        test_random_jobs();
        test_reset_midrun();
`ifdef RESULT_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
